// File: rtl/pixel_line_gen.sv
// Line timing generator: walks pixel columns, inserts horizontal blanking,
// pulses newLine once per line and asks the frame counter (endFrame) whether
// to run another line or finish the frame. All outputs are registered.
module pixel_line_gen #(
    parameter int LINE_PIXELS = 32,
    parameter int HBLANK      = 4,
    parameter int COL_W       = 6,
    parameter int BLK_W       = 3
) (
    input  logic             clk,
    input  logic             rst_n,     // active-high async reset despite the name
    input  logic             enb,
    input  logic             start,
    input  logic             endFrame,
    output logic             newLine,
    output logic             pixValid,
    output logic [COL_W-1:0] col,
    output logic             busy,
    output logic             frameDone
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HBLANK = 2'd2;
    localparam logic [1:0] S_CHECK  = 2'd3;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_PIXELS - 1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(HBLANK - 1);

    logic [1:0]       state, state_nx;
    logic [COL_W-1:0] col_nx;
    logic [BLK_W-1:0] blk, blk_nx;
    logic             done_nx;

    // Next-state and next-counter logic; enb low overrides everything.
    always_comb begin
        state_nx = state;
        col_nx   = col;
        blk_nx   = blk;
        done_nx  = 1'b0;
        if (!enb) begin
            state_nx = S_IDLE;
            col_nx   = '0;
            blk_nx   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    col_nx = '0;
                    blk_nx = '0;
                    if (start) state_nx = S_ACTIVE;
                end
                S_ACTIVE: begin
                    if (col == COL_LAST) begin
                        state_nx = S_HBLANK;
                        col_nx   = '0;
                        blk_nx   = '0;
                    end else begin
                        col_nx = col + COL_W'(1);
                    end
                end
                S_HBLANK: begin
                    if (blk == BLK_LAST) begin
                        state_nx = S_CHECK;
                        blk_nx   = '0;
                    end else begin
                        blk_nx = blk + BLK_W'(1);
                    end
                end
                default: begin // S_CHECK: endFrame is only meaningful here
                    col_nx = '0;
                    if (endFrame) begin
                        state_nx = S_IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        state_nx = S_ACTIVE;
                    end
                end
            endcase
        end
    end

    // State, counters and Moore outputs registered from the next-state values.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state     <= S_IDLE;
            col       <= '0;
            blk       <= '0;
            pixValid  <= 1'b0;
            newLine   <= 1'b0;
            busy      <= 1'b0;
            frameDone <= 1'b0;
        end else begin
            state     <= state_nx;
            col       <= col_nx;
            blk       <= blk_nx;
            pixValid  <= (state_nx == S_ACTIVE);
            newLine   <= (state_nx == S_HBLANK) && (blk_nx == BLK_LAST);
            busy      <= (state_nx != S_IDLE);
            frameDone <= done_nx;
        end
    end

endmodule

// File: tb/tb_pixel_line_gen.sv
// Bench for pixel_line_gen: default geometry with a 24-line frame counter
// model attached, plus a LINE_PIXELS=1/HBLANK=1 instance.
module tb_pixel_line_gen;

    logic       clk = 1'b0;
    logic       rst, enb, start, start1;
    logic       newLine, pixValid, busy, frameDone, endFrame;
    logic [5:0] col;
    logic       newLine1, pixValid1, busy1, frameDone1, endFrame1;
    logic [5:0] col1;
    int         fc, fc1;
    int         tests = 0;
    int         fails = 0;
    int         nl_cnt, fd_cnt;

    always #30 clk = ~clk;

    pixel_line_gen dut (
        .clk(clk), .rst_n(rst), .enb(enb), .start(start), .endFrame(endFrame),
        .newLine(newLine), .pixValid(pixValid), .col(col), .busy(busy),
        .frameDone(frameDone)
    );

    pixel_line_gen #(.LINE_PIXELS(1), .HBLANK(1)) dut1 (
        .clk(clk), .rst_n(rst), .enb(enb), .start(start1), .endFrame(endFrame1),
        .newLine(newLine1), .pixValid(pixValid1), .col(col1), .busy(busy1),
        .frameDone(frameDone1)
    );

    // Frame line counters: count newLine, clear on enb low or frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fc <= 0;
        else if (!enb || frameDone) fc <= 0;
        else if (newLine) fc <= fc + 1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fc1 <= 0;
        else if (!enb || frameDone1) fc1 <= 0;
        else if (newLine1) fc1 <= fc1 + 1;
    end
    assign endFrame  = (fc == 24);
    assign endFrame1 = (fc1 == 24);

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " pix"},  int'(pixValid),  0);
        chk({tag, " nl"},   int'(newLine),   0);
        chk({tag, " busy"}, int'(busy),      0);
        chk({tag, " fd"},   int'(frameDone), 0);
        chk({tag, " col"},  int'(col),       0);
    endtask

    // Expected default-geometry outputs for period n of a running frame (n<=888).
    task automatic chk_period(input int n);
        int p;
        p = (n - 1) % 37;
        chk($sformatf("c%0d pix", n),  int'(pixValid), (p < 32) ? 1 : 0);
        chk($sformatf("c%0d col", n),  int'(col),      (p < 32) ? p : 0);
        chk($sformatf("c%0d nl", n),   int'(newLine),  (p == 35) ? 1 : 0);
        chk($sformatf("c%0d busy", n), int'(busy),     1);
        chk($sformatf("c%0d fd", n),   int'(frameDone), 0);
        if (newLine) nl_cnt++;
    endtask

    initial begin
        rst = 1'b1; enb = 1'b0; start = 1'b0; start1 = 1'b0;
        #100;
        chk_idle("reset");

        // start with enb low is ignored
        @(negedge clk); rst = 1'b0; start = 1'b1;
        @(negedge clk); @(negedge clk);
        chk_idle("start_no_enb");
        start = 1'b0;

        // full frame; a stray start at cycle 10 must not disturb timing
        enb = 1'b1; start = 1'b1; nl_cnt = 0;
        for (int n = 1; n <= 888; n++) begin
            @(negedge clk);
            chk_period(n);
            start = (n == 10);
        end
        @(negedge clk);
        chk("c889 fd",   int'(frameDone), 1);
        chk("c889 busy", int'(busy),      0);
        chk("c889 pix",  int'(pixValid),  0);
        chk("frame newLine count", nl_cnt, 24);
        start = 1'b1;   // restart in the frameDone cycle

        // restarted frame, enb dropped during cycle 50
        nl_cnt = 0;
        for (int m = 1; m <= 50; m++) begin
            @(negedge clk);
            chk_period(m);
            start = 1'b0;
        end
        enb = 1'b0;
        nl_cnt = 0; fd_cnt = 0;
        @(negedge clk);
        chk_idle("enb_drop c51");
        for (int m = 0; m < 40; m++) begin
            @(negedge clk);
            if (newLine) nl_cnt++;
            if (frameDone) fd_cnt++;
        end
        chk("after enb drop newLine", nl_cnt, 0);
        chk("after enb drop frameDone", fd_cnt, 0);

        // re-enable and start; async reset in HBLANK of line 1
        enb = 1'b1; start = 1'b1;
        for (int m = 1; m <= 34; m++) begin
            @(negedge clk);
            chk_period(m);
            start = 1'b0;
        end
        #10 rst = 1'b1;
        #1 chk_idle("async_rst");
        #5 rst = 1'b0;
        @(negedge clk);
        chk_idle("after_rst");

        // 1-pixel, 1-blank instance: 3-cycle lines, frameDone at cycle 73
        start1 = 1'b1; nl_cnt = 0;
        for (int n = 1; n <= 75; n++) begin
            int p;
            @(negedge clk);
            start1 = 1'b0;
            p = (n - 1) % 3;
            if (n <= 72) begin
                chk($sformatf("s c%0d pix", n),  int'(pixValid1), (p == 0) ? 1 : 0);
                chk($sformatf("s c%0d nl", n),   int'(newLine1),  (p == 1) ? 1 : 0);
                chk($sformatf("s c%0d busy", n), int'(busy1),     1);
            end else begin
                chk($sformatf("s c%0d busy", n), int'(busy1), 0);
            end
            chk($sformatf("s c%0d fd", n), int'(frameDone1), (n == 73) ? 1 : 0);
            chk($sformatf("s c%0d col", n), int'(col1), 0);
            if (newLine1) nl_cnt++;
        end
        chk("small frame newLine count", nl_cnt, 24);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
